keccak_pi_permute: RTL and testbench
====================================

# keccak_pi_permute

Lane-serial pi-permutation stage of the encoder's Keccak round, sitting directly downstream of the rho rotate stage. Accepts the 25 rotated 64-bit lanes of one state in natural order (index i = x + 5y) over a valid/ready handshake, buffers the full state, then emits the 25 lanes in pi-permuted order over a second valid/ready handshake. Lane positions are tracked with internal mod-25 counters.

## Interface
- No parameters; lane width fixed at 64, lane count fixed at 25.
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  upstream lane valid
- in_lane  in  64  rotated lane, natural order
- in_ready  out  1  block can accept a lane
- out_valid  out  1  permuted lane available
- out_lane  out  64  permuted lane
- out_idx  out  5  destination index j (0..24) of out_lane
- out_last  out  1  high with out_valid when out_idx = 24
- out_ready  in  1  downstream accepts lane
- frame_done  out  1  one-cycle pulse after the 25th output is accepted

## Operation
- State buffer: 25 x 64-bit registers buf[0..24].
- FSM states: LOAD, SEND.
- LOAD: in_ready = 1, out_valid = 0. On in_valid & in_ready: buf[wr_cnt] <= in_lane; wr_cnt increments. Accept with wr_cnt = 24: wr_cnt <= 0, next state SEND.
- SEND: in_ready = 0, out_valid = 1, out_idx = rd_cnt, out_lane = buf[src(rd_cnt)]. On out_valid & out_ready: rd_cnt increments. Accept with rd_cnt = 24: rd_cnt <= 0, next state LOAD, frame_done = 1 in the following cycle.
- Pi mapping, destination j = x' + 5y' (x', y' in 0..4): x = (x' + 3y') mod 5, y = x'; src(j) = x + 5y. Implemented as a fixed 25-entry 5-bit lookup; no runtime arithmetic beyond mod-25 counting.
- Sample values: src(0)=0, src(1)=6, src(2)=12, src(5)=3, src(24)=21.
- Counters wr_cnt, rd_cnt: 5-bit, count 0..24, wrap to 0 after 24; values 25..31 unreachable.
- in_lane ignored when in_valid = 0 or in_ready = 0; out_lane held stable while out_valid & !out_ready.
- Single buffer: no overlap of load and send; upstream stalls during SEND.

## Timing
- Reset values: state LOAD, wr_cnt = 0, rd_cnt = 0, buf all 0, in_ready = 1, out_valid = 0, out_idx = 0, out_last = 0, frame_done = 0. out_lane = buf[0] = 0 (don't-care while out_valid = 0).
- in_ready, out_valid, out_last, out_idx decoded from registered state/counters only; out_lane is a combinational mux of registered buffer; no combinational path from in_valid/out_ready to any output.
- Latency: 25th input accepted at edge N -> out_valid = 1 with out_idx = 0 in cycle after N.
- Minimum frame period: 50 cycles (25 load + 25 send) with in_valid and out_ready held high.
- frame_done high exactly one cycle, coincident with in_ready returning to 1.
- rst asserted mid-LOAD or mid-SEND: immediate return to reset values; partial frame discarded; first accepted lane after release goes to buf[0].
- out_ready stalls: rd_cnt, out_idx, out_lane held; no lane skipped or duplicated.

## Test plan
- Reset: assert rst mid-cycle -> in_ready = 1, out_valid = 0, frame_done = 0 immediately, without a clock edge.
- Full frame, no stalls: in_lane = 0x1000 + i for i = 0..24 -> outputs j = 0..24 equal 0x1000 + src(j); j=1 gives 0x1006, j=5 gives 0x1003, j=24 gives 0x1015 with out_last = 1; frame_done pulses once; 50-cycle period.
- Back-pressure: random in_valid gaps and out_ready toggles -> identical output sequence; out_lane stable across stalled cycles; in_ready = 0 throughout SEND.
- Back-to-back frames: two frames with distinct patterns -> second frame loads starting at buf[0] in the frame_done cycle; no mixing of lanes.
- Reset mid-SEND after 10 outputs: then new frame -> emission restarts at out_idx = 0 with new data only.
- Exhaustive mapping: one-hot lane tag in_lane = 1 << i -> every output j carries bit src(j); all 25 sources used exactly once.

Source files
------------

// File: rtl/keccak_pi_permute_if.sv
// Lane handshake bundle for the Keccak pi stage: upstream valid/ready in,
// downstream valid/ready out, plus the frame-done pulse and a state tap.
//
// Handshake rule for both sides: a lane transfers on a rising clk edge where
// valid and ready are both high. A valid lane is not withdrawn or changed
// until it transfers, and ready never depends combinationally on valid.
interface keccak_pi_permute_if;
  logic        in_valid;
  logic [63:0] in_lane;
  logic        in_ready;
  logic        out_valid;
  logic [63:0] out_lane;
  logic [4:0]  out_idx;
  logic        out_last;
  logic        out_ready;
  logic        frame_done;
  logic [0:0]  state_dbg;

  modport master (
    output in_valid, in_lane, out_ready,
    input  in_ready, out_valid, out_lane, out_idx, out_last, frame_done, state_dbg
  );

  modport slave (
    input  in_valid, in_lane, out_ready,
    output in_ready, out_valid, out_lane, out_idx, out_last, frame_done, state_dbg
  );
endinterface

// File: rtl/keccak_pi_permute.sv
// Lane-serial Keccak pi stage: buffers the 25 rho-rotated lanes of one state
// in natural order, then emits them in pi-permuted order. One buffer, so the
// upstream side is stalled for the whole send phase.
module keccak_pi_permute (
  input  logic            clk,
  input  logic            rst,
  keccak_pi_permute_if.slave bus
);

  localparam logic [0:0] LOAD = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]  state;
  logic [4:0]  wr_cnt;
  logic [4:0]  rd_cnt;
  logic        done_q;
  logic [63:0] lane_buf [25];
  logic [4:0]  src_idx;
  logic        in_fire;
  logic        out_fire;

  assign in_fire  = bus.in_valid  && (state == LOAD);
  assign out_fire = bus.out_ready && (state == SEND);

  // Phase FSM, lane counters and the registered end-of-frame pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= LOAD;
      wr_cnt <= 5'd0;
      rd_cnt <= 5'd0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (in_fire) begin
        if (wr_cnt == 5'd24) begin
          wr_cnt <= 5'd0;
          state  <= SEND;
        end else begin
          wr_cnt <= wr_cnt + 5'd1;
        end
      end
      if (out_fire) begin
        if (rd_cnt == 5'd24) begin
          rd_cnt <= 5'd0;
          state  <= LOAD;
          done_q <= 1'b1;
        end else begin
          rd_cnt <= rd_cnt + 5'd1;
        end
      end
    end
  end

  // State buffer: each accepted lane lands at its natural index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 25; i++) lane_buf[i] <= 64'd0;
    end else if (in_fire) begin
      lane_buf[wr_cnt] <= bus.in_lane;
    end
  end

  // Pi source lookup: destination j = x'+5y' reads lane x+5y with
  // x = (x'+3y') mod 5, y = x'. Fixed table, no arithmetic.
  always_comb begin
    src_idx = 5'd0;
    case (rd_cnt)
      5'd0:  src_idx = 5'd0;
      5'd1:  src_idx = 5'd6;
      5'd2:  src_idx = 5'd12;
      5'd3:  src_idx = 5'd18;
      5'd4:  src_idx = 5'd24;
      5'd5:  src_idx = 5'd3;
      5'd6:  src_idx = 5'd9;
      5'd7:  src_idx = 5'd10;
      5'd8:  src_idx = 5'd16;
      5'd9:  src_idx = 5'd22;
      5'd10: src_idx = 5'd1;
      5'd11: src_idx = 5'd7;
      5'd12: src_idx = 5'd13;
      5'd13: src_idx = 5'd19;
      5'd14: src_idx = 5'd20;
      5'd15: src_idx = 5'd4;
      5'd16: src_idx = 5'd5;
      5'd17: src_idx = 5'd11;
      5'd18: src_idx = 5'd17;
      5'd19: src_idx = 5'd23;
      5'd20: src_idx = 5'd2;
      5'd21: src_idx = 5'd8;
      5'd22: src_idx = 5'd14;
      5'd23: src_idx = 5'd15;
      5'd24: src_idx = 5'd21;
      default: src_idx = 5'd0;
    endcase
  end

  assign bus.in_ready   = (state == LOAD);
  assign bus.out_valid  = (state == SEND);
  assign bus.out_idx    = rd_cnt;
  assign bus.out_last   = (state == SEND) && (rd_cnt == 5'd24);
  assign bus.out_lane   = lane_buf[src_idx];
  assign bus.frame_done = done_q;
  assign bus.state_dbg  = state;

endmodule

// File: tb/tb_keccak_pi_permute.sv
// Bench for keccak_pi_permute: directed frames, a vector table for sample
// pi destinations, randomized back-pressure, reset mid-send, one-hot mapping.
module tb_keccak_pi_permute;

  logic clk;
  logic rst;
  keccak_pi_permute_if bus ();

  keccak_pi_permute dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] exp_q [$];
  logic [63:0] got [25];
  logic        fd_expected = 1'b0;
  int          last_period = 0;

  typedef struct {
    int          j;
    logic [63:0] lane;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference pi mapping computed from coordinates.
  function automatic int src_of(input int j);
    int xp, yp, x, y;
    xp = j % 5;
    yp = j / 5;
    x  = (xp + 3 * yp) % 5;
    y  = xp;
    return x + 5 * y;
  endfunction

  // Assert reset between edges and check outputs before any edge arrives.
  task automatic mid_reset();
    #2 rst = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    check("rst_in_ready",   {63'd0, bus.in_ready},   64'd1);
    check("rst_out_valid",  {63'd0, bus.out_valid},  64'd0);
    check("rst_frame_done", {63'd0, bus.frame_done}, 64'd0);
    check("rst_out_idx",    {59'd0, bus.out_idx},    64'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    fd_expected = 1'b0;
  endtask

  // ---------------- driver + scoreboard ----------------
  // Drives one frame; abort_after >= 0 resets the block once that many lanes
  // have been emitted.
  task automatic run_frame(input logic [63:0] data [25], input int in_gap,
                           input int out_stall, input int abort_after);
    int sent = 0;
    int recv = 0;
    int cyc  = 0;
    logic in_send;
    logic stalled = 1'b0;
    logic [63:0] prev_lane = 64'd0;
    for (int j = 0; j < 25; j++) exp_q.push_back(data[src_of(j)]);
    while (recv < 25) begin
      @(negedge clk);
      cyc++;
      if (cyc > 3000) begin
        check("timeout", 64'(recv), 64'd25);
        exp_q.delete();
        return;
      end
      check("frame_done", {63'd0, bus.frame_done}, {63'd0, fd_expected});
      fd_expected = 1'b0;
      in_send = (sent == 25);
      if (!in_send) begin
        check("load_in_ready",  {63'd0, bus.in_ready},  64'd1);
        check("load_out_valid", {63'd0, bus.out_valid}, 64'd0);
        bus.in_valid  = ($urandom_range(99) >= in_gap);
        bus.in_lane   = bus.in_valid ? data[sent] : {$urandom, $urandom};
        bus.out_ready = $urandom_range(1);
        if (bus.in_valid) sent++;
      end else begin
        bus.in_valid = $urandom_range(1);
        bus.in_lane  = {$urandom, $urandom};
        if (abort_after >= 0 && recv == abort_after) begin
          mid_reset();
          return;
        end
        check("send_in_ready",  {63'd0, bus.in_ready},  64'd0);
        check("send_out_valid", {63'd0, bus.out_valid}, 64'd1);
        check("out_idx",        {59'd0, bus.out_idx},   64'(recv));
        check("out_last",       {63'd0, bus.out_last},  {63'd0, recv == 24});
        check("out_lane",       bus.out_lane,           exp_q[0]);
        if (stalled) check("stall_hold", bus.out_lane, prev_lane);
        prev_lane     = bus.out_lane;
        bus.out_ready = ($urandom_range(99) >= out_stall);
        stalled       = !bus.out_ready;
        if (bus.out_ready) begin
          got[recv] = bus.out_lane;
          void'(exp_q.pop_front());
          recv++;
        end
      end
    end
    last_period = cyc;
    fd_expected = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("idle_frame_done", {63'd0, bus.frame_done}, {63'd0, fd_expected});
      check("idle_in_ready",   {63'd0, bus.in_ready},   64'd1);
      check("idle_out_valid",  {63'd0, bus.out_valid},  64'd0);
      fd_expected = 1'b0;
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [63:0] data [25];
    logic [63:0] seen;
    vec_t vecs [5];
    vecs[0] = '{j: 0,  lane: 64'h1000};
    vecs[1] = '{j: 1,  lane: 64'h1006};
    vecs[2] = '{j: 2,  lane: 64'h100C};
    vecs[3] = '{j: 5,  lane: 64'h1003};
    vecs[4] = '{j: 24, lane: 64'h1015};

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_lane   = 64'd0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_in_ready",   {63'd0, bus.in_ready},   64'd1);
    check("reset_out_valid",  {63'd0, bus.out_valid},  64'd0);
    check("reset_out_idx",    {59'd0, bus.out_idx},    64'd0);
    check("reset_out_last",   {63'd0, bus.out_last},   64'd0);
    check("reset_frame_done", {63'd0, bus.frame_done}, 64'd0);
    check("reset_out_lane",   bus.out_lane,            64'd0);
    rst = 1'b0;

    // Full frame, no stalls, with sample destinations from the table.
    for (int i = 0; i < 25; i++) data[i] = 64'h1000 + 64'(i);
    run_frame(data, 0, 0, -1);
    check("period_frame1", 64'(last_period), 64'd50);
    for (int v = 0; v < 5; v++) check($sformatf("vec_j%0d", vecs[v].j), got[vecs[v].j], vecs[v].lane);

    // Back-to-back frame loading in the frame_done cycle.
    for (int i = 0; i < 25; i++) data[i] = 64'hA5A5_0000_0000_0000 | (64'(i) << 8);
    run_frame(data, 0, 0, -1);
    check("period_frame2", 64'(last_period), 64'd50);

    // Random data with upstream gaps and downstream stalls.
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 25; i++) data[i] = {$urandom, $urandom};
      run_frame(data, 30, 40, -1);
    end
    idle(2);

    // Reset after 10 emitted lanes, then a fresh frame.
    for (int i = 0; i < 25; i++) data[i] = 64'hDEAD_0000_0000_0000 | 64'(i);
    run_frame(data, 10, 20, 10);
    for (int i = 0; i < 25; i++) data[i] = 64'h7777_0000_0000_0000 | 64'(i * 3);
    run_frame(data, 0, 25, -1);

    // One-hot lane tags: each output carries exactly bit src(j), all used once.
    for (int i = 0; i < 25; i++) data[i] = 64'd1 << i;
    run_frame(data, 0, 0, -1);
    seen = 64'd0;
    for (int j = 0; j < 25; j++) begin
      check($sformatf("onehot_j%0d", j), got[j], 64'd1 << src_of(j));
      seen = seen | got[j];
    end
    check("onehot_cover", seen, 64'h1FF_FFFF);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
